// File: rtl/vga_timing_engine_if.sv
// Framebuffer read bus: vga_timing_engine drives the request (master) and
// the pixel memory answers with data RD_LAT pixel ticks later (slave).
interface vga_timing_engine_if #(
   parameter int unsigned COLOR_W = 12
);
   logic               o_rd_en;
   logic [10:0]        o_rd_x;
   logic [10:0]        o_rd_y;
   logic [COLOR_W-1:0] i_rd_data;

   modport master (output o_rd_en, output o_rd_x, output o_rd_y, input i_rd_data);
   modport slave  (input o_rd_en, input o_rd_x, input o_rd_y, output i_rd_data);
endinterface

// File: rtl/vga_timing_engine.sv
// Programmable VGA timing generator: beam counters, framebuffer read requests
// ahead of the beam, and a delay line that re-aligns sync/DE with returned pixels.
module vga_timing_engine #(
   parameter int unsigned        H_SYNC     = 128,
   parameter int unsigned        H_BP       = 88,
   parameter int unsigned        H_ACTIVE   = 800,
   parameter int unsigned        H_FP       = 40,
   parameter int unsigned        V_SYNC     = 4,
   parameter int unsigned        V_BP       = 23,
   parameter int unsigned        V_ACTIVE   = 600,
   parameter int unsigned        V_FP       = 1,
   parameter bit                 HS_POL     = 1'b0,
   parameter bit                 VS_POL     = 1'b0,
   parameter int unsigned        SRC_W      = 640,
   parameter int unsigned        SRC_H      = 480,
   parameter int unsigned        SCALE_LOG2 = 0,
   parameter int unsigned        RD_LAT     = 1,
   parameter int unsigned        COLOR_W    = 12,
   parameter logic [COLOR_W-1:0] BORDER     = COLOR_W'(12'h00F)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_pix_en,
   vga_timing_engine_if.master  rd_if,
   output logic [COLOR_W-1:0]   o_color,
   output logic                 o_hs,
   output logic                 o_vs,
   output logic                 o_de,
   output logic                 o_frame_start,
   output logic                 o_vblank
);

   localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

   localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
   localparam logic [11:0] H_START    = 12'(H_SYNC + H_BP);
   localparam logic [11:0] H_STOP     = 12'(H_SYNC + H_BP + H_ACTIVE - 1);
   localparam logic [11:0] H_SYNC_END = 12'(H_SYNC);
   localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
   localparam logic [11:0] V_START    = 12'(V_SYNC + V_BP);
   localparam logic [11:0] V_STOP     = 12'(V_SYNC + V_BP + V_ACTIVE - 1);
   localparam logic [11:0] V_SYNC_END = 12'(V_SYNC);
   localparam logic [12:0] SRC_W_L    = 13'(SRC_W);
   localparam logic [12:0] SRC_H_L    = 13'(SRC_H);

   // Beam attributes evaluated at the counters, carried until the pixel returns.
   typedef struct packed {
      logic sync_h;
      logic sync_v;
      logic de;
      logic win;
      logic vblank;
      logic frame;
   } beam_t;

   localparam beam_t BEAM_IDLE = '{sync_h: 1'b0, sync_v: 1'b0, de: 1'b0,
                                   win: 1'b0, vblank: 1'b1, frame: 1'b0};

   logic [11:0] h_q, h_d, v_q, v_d;
   logic [11:0] hpos, vpos, src_x, src_y;
   logic        h_act, v_act, in_win;
   beam_t       beam_now, beam_out;
   beam_t       dl_q [RD_LAT];
   logic [10:0] rd_x_q, rd_x_d, rd_y_q, rd_y_d;

   logic [COLOR_W-1:0] color_q, color_d;
   logic hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d, vb_q, vb_d;

   // NOTE: every always_comb target gets a default first, so no path can infer a latch.
   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (i_pix_en) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 12'd1;
         end else begin
            h_d = h_q + 12'd1;
         end
      end
   end

   always_comb begin
      h_act    = (h_q >= H_START) && (h_q <= H_STOP);
      v_act    = (v_q >= V_START) && (v_q <= V_STOP);
      hpos     = h_q - H_START;
      vpos     = v_q - V_START;
      src_x    = hpos >> SCALE_LOG2;
      src_y    = vpos >> SCALE_LOG2;
      in_win   = h_act && v_act && ({1'b0, src_x} < SRC_W_L) && ({1'b0, src_y} < SRC_H_L);

      beam_now        = BEAM_IDLE;
      beam_now.sync_h = (h_q < H_SYNC_END);
      beam_now.sync_v = (v_q < V_SYNC_END);
      beam_now.de     = h_act && v_act;
      beam_now.win    = in_win;
      beam_now.vblank = !v_act;
      beam_now.frame  = (h_q == H_START) && (v_q == V_START);

      // Address follows the beam inside the window and parks on the last request outside it.
      rd_x_d = in_win ? src_x[10:0] : rd_x_q;
      rd_y_d = in_win ? src_y[10:0] : rd_y_q;

      rd_if.o_rd_en = i_pix_en && in_win && !reset;
      rd_if.o_rd_x  = rd_x_d;
      rd_if.o_rd_y  = rd_y_d;
   end

   assign beam_out = dl_q[RD_LAT-1];

   always_comb begin
      color_d = color_q;
      hs_d    = hs_q;
      vs_d    = vs_q;
      de_d    = de_q;
      vb_d    = vb_q;
      fs_d    = 1'b0;
      if (i_pix_en) begin
         color_d = beam_out.de ? (beam_out.win ? rd_if.i_rd_data : BORDER) : '0;
         hs_d    = beam_out.sync_h ? HS_POL : ~HS_POL;
         vs_d    = beam_out.sync_v ? VS_POL : ~VS_POL;
         de_d    = beam_out.de;
         vb_d    = beam_out.vblank;
         fs_d    = beam_out.frame;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         h_q     <= '0;
         v_q     <= '0;
         rd_x_q  <= '0;
         rd_y_q  <= '0;
         color_q <= '0;
         hs_q    <= ~HS_POL;
         vs_q    <= ~VS_POL;
         de_q    <= 1'b0;
         fs_q    <= 1'b0;
         vb_q    <= 1'b1;
      end else begin
         h_q     <= h_d;
         v_q     <= v_d;
         rd_x_q  <= rd_x_d;
         rd_y_q  <= rd_y_d;
         color_q <= color_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         de_q    <= de_d;
         fs_q    <= fs_d;
         vb_q    <= vb_d;
      end
   end

   // NOTE: the delay line is a small shift register, so it is cleared on reset; a dropped
   // frame must not leak stale sync/DE flags to the pins.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(RD_LAT); i++) dl_q[i] <= BEAM_IDLE;
      end else if (i_pix_en) begin
         dl_q[0] <= beam_now;
         for (int i = 1; i < int'(RD_LAT); i++) dl_q[i] <= dl_q[i-1];
      end
   end

   assign o_color       = color_q;
   assign o_hs          = hs_q;
   assign o_vs          = vs_q;
   assign o_de          = de_q;
   assign o_frame_start = fs_q;
   assign o_vblank      = vb_q;

endmodule
